mem_bus_ctrl: RTL

Memory-bus controller sitting directly downstream of the CPU controller. It consumes the `mem_cmd`/address/write-data request produced by the controller and datapath, arbitrates between 256-word on-chip RAM and memory-mapped I/O (switches, LEDs), and returns read data with a one-cycle `mem_ready` completion pulse. RAM wait states are programmable so slower memory macros can be dropped in without touching the controller FSM.

---
 rtl/mem_bus_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU memory-bus controller steering requests to on-chip RAM, LED and switch I/O.
// Define MEM_BUS_ERR_EN to build the sticky bus_err detector; otherwise bus_err is tied low.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [8:0]  LED_ADDR    = 9'h100,
    parameter logic [8:0]  SW_ADDR     = 9'h140
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        bus_err
);
    localparam logic [1:0] CMD_WR = 2'b11;

    typedef enum logic [1:0] {IDLE, RAM_RD, WR, DONE} state_t;

    state_t      state;
    logic [8:0]  addr_q;
    logic [1:0]  cmd_q;
    logic [15:0] wdata_q;
    logic [2:0]  cnt;

    assign mem_ready = state == DONE;
    assign ram_we    = state == WR && cmd_q == CMD_WR && !addr_q[8];
    assign ram_addr  = addr_q[7:0];
    assign ram_wdata = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            cmd_q     <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            read_data <= '0;
            led       <= '0;
        end else begin
            case (state)
                IDLE: if (mem_cmd[0]) begin
                    addr_q  <= mem_addr;
                    cmd_q   <= mem_cmd;
                    wdata_q <= write_data;
                    if (mem_cmd[1]) begin
                        state <= WR;
                    end else if (!mem_addr[8]) begin
                        state <= RAM_RD;
                        cnt   <= 3'(WAIT_STATES);
                    end else begin
                        // I/O reads complete on the accept edge; anything but the switches reads as zero
                        read_data <= mem_addr == SW_ADDR ? {8'h00, sw} : 16'h0000;
                        state     <= DONE;
                    end
                end
                RAM_RD: if (cnt == 3'd1) begin
                    read_data <= ram_rdata;
                    state     <= DONE;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                WR: begin
                    if (cmd_q == CMD_WR && addr_q == LED_ADDR) led <= wdata_q[7:0];
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_BUS_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus_err <= 1'b0;
        else if (state == IDLE && (mem_cmd == 2'b10 ||
                 (mem_cmd[0] && mem_addr[8] && mem_addr != (mem_cmd[1] ? LED_ADDR : SW_ADDR))))
            bus_err <= 1'b1;
    end
`else
    assign bus_err = 1'b0;
`endif
endmodule
